// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780 character sequencer:
// FSM states, slave address encodings and the power-on init ROM.
package lcd_seq_pkg;

    typedef enum logic [3:0] {
        S_POWERON,
        S_INIT_LOAD,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_WAIT,
        S_POLL_SETUP,
        S_POLL_E,
        S_POLL_HOLD,
        S_IDLE
    } state_t;

    localparam logic [1:0] LCD_ADDR_CMD_W  = 2'b00;
    localparam logic [1:0] LCD_ADDR_BUSY_R = 2'b01;
    localparam logic [1:0] LCD_ADDR_DATA_W = 2'b10;

    localparam logic [7:0] LCD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON = 8'h0C;
    localparam logic [7:0] LCD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_ENTRY   = 8'h06;

    localparam int INIT_LEN = 7;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd4:    init_rom = LCD_DISP_ON;
            3'd5:    init_rom = LCD_CLEAR;
            3'd6:    init_rom = LCD_ENTRY;
            default: init_rom = LCD_FUNCSET;
        endcase
    endfunction

    // A zero-length phase still occupies one cycle.
    function automatic int lcd_cyc(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Loading a length N makes done rise N-1 cycles later (a phase of N cycles).
module lcd_seq_timer #(
    parameter int W         = 20,
    parameter int RESET_LEN = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= W'(RESET_LEN - 1);
        end else if (load) begin
            cnt <= len - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_char_sequencer.sv
// Bus master for the combinational HD44780 Avalon slave: power-on init, then
// command/data bytes over valid/ready with full E-cycle timing and BF polling.
module lcd_char_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int SETUP_CYC        = 3,
    parameter int E_CYC            = 23,
    parameter int HOLD_CYC         = 2,
    parameter int POWERON_CYC      = 750000,
    parameter int INIT_WAIT_CYC    = 205000,
    parameter int CMD_WAIT_CYC     = 2000,
    parameter int CLEAR_WAIT_CYC   = 82000,
    parameter int USE_BUSY         = 1,
    parameter int BUSY_TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       busy_timeout,
    output logic [1:0] lcd_address,
    output logic       lcd_read,
    output logic       lcd_write,
    output logic [7:0] lcd_writedata,
    input  logic [7:0] lcd_readdata
);

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, E_CYC), max2(HOLD_CYC, POWERON_CYC)),
                                  max2(max2(INIT_WAIT_CYC, CMD_WAIT_CYC),
                                       max2(CLEAR_WAIT_CYC, BUSY_TIMEOUT_CYC)));
    localparam int CW = $clog2(MAX_CYC + 2);

    localparam logic [CW-1:0] L_SETUP   = CW'(lcd_cyc(SETUP_CYC));
    localparam logic [CW-1:0] L_E       = CW'(lcd_cyc(E_CYC));
    localparam logic [CW-1:0] L_HOLD    = CW'(lcd_cyc(HOLD_CYC));
    localparam logic [CW-1:0] L_INIT    = CW'(lcd_cyc(INIT_WAIT_CYC));
    localparam logic [CW-1:0] L_CMD     = CW'(lcd_cyc(CMD_WAIT_CYC));
    localparam logic [CW-1:0] L_CLEAR   = CW'(lcd_cyc(CLEAR_WAIT_CYC));
    localparam logic [CW-1:0] L_TO_LAST = CW'(lcd_cyc(BUSY_TIMEOUT_CYC) - 1);

    state_t        state;
    logic [2:0]    step;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          bf_q;
    logic [CW-1:0] poll_cnt;

    logic          tmr_load;
    logic [CW-1:0] tmr_len;
    logic          tmr_done;
    logic          is_clear;
    logic          use_poll;
    logic          poll_hit;
    logic          finish;
    logic [CW-1:0] fixed_wait;
    logic          unused_bits;

    assign unused_bits = ^lcd_readdata[6:0];

    assign is_clear   = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign use_poll   = (USE_BUSY != 0) && (init_done || step >= 3'd3);
    assign fixed_wait = (!init_done && step < 3'd3) ? L_INIT : (is_clear ? L_CLEAR : L_CMD);
    assign poll_hit   = (poll_cnt >= L_TO_LAST);
    assign finish     = tmr_done && ((state == S_WAIT) ||
                                     (state == S_POLL_HOLD && (!bf_q || poll_hit)));

    // The timer is reloaded with the length of whichever phase comes next.
    always_comb begin
        tmr_load = 1'b0;
        tmr_len  = L_SETUP;
        case (state)
            S_INIT_LOAD, S_IDLE: tmr_load = 1'b1;
            S_SETUP, S_POLL_SETUP: begin
                tmr_load = tmr_done;
                tmr_len  = L_E;
            end
            S_EHIGH, S_POLL_E: begin
                tmr_load = tmr_done;
                tmr_len  = L_HOLD;
            end
            S_HOLD: begin
                tmr_load = tmr_done;
                tmr_len  = use_poll ? L_SETUP : fixed_wait;
            end
            S_POLL_HOLD: tmr_load = tmr_done;
            default: ;
        endcase
    end

    lcd_seq_timer #(
        .W         (CW),
        .RESET_LEN (lcd_cyc(POWERON_CYC))
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .len     (tmr_len),
        .done    (tmr_done)
    );

    // Handshake: a byte transfers on an edge where in_valid && in_ready; in_ready
    // is high only in S_IDLE and the producer must hold its byte until then.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_POWERON;
            step          <= 3'd0;
            rs_q          <= 1'b0;
            data_q        <= 8'h00;
            bf_q          <= 1'b0;
            poll_cnt      <= '0;
            in_ready      <= 1'b0;
            init_done     <= 1'b0;
            busy_timeout  <= 1'b0;
            lcd_address   <= LCD_ADDR_CMD_W;
            lcd_read      <= 1'b0;
            lcd_write     <= 1'b0;
            lcd_writedata <= 8'h00;
        end else begin
            if ((state == S_POLL_SETUP || state == S_POLL_E || state == S_POLL_HOLD) &&
                poll_cnt < L_TO_LAST) begin
                poll_cnt <= poll_cnt + CW'(1);
            end
            case (state)
                S_POWERON: if (tmr_done) state <= S_INIT_LOAD;
                S_INIT_LOAD: begin
                    rs_q          <= 1'b0;
                    data_q        <= init_rom(step);
                    lcd_address   <= LCD_ADDR_CMD_W;
                    lcd_writedata <= init_rom(step);
                    state         <= S_SETUP;
                end
                S_IDLE: if (in_valid && in_ready) begin
                    rs_q          <= in_rs;
                    data_q        <= in_data;
                    lcd_address   <= in_rs ? LCD_ADDR_DATA_W : LCD_ADDR_CMD_W;
                    lcd_writedata <= in_data;
                    in_ready      <= 1'b0;
                    state         <= S_SETUP;
                end
                S_SETUP: if (tmr_done) begin
                    lcd_write <= 1'b1;
                    state     <= S_EHIGH;
                end
                S_EHIGH: if (tmr_done) begin
                    lcd_write <= 1'b0;
                    state     <= S_HOLD;
                end
                S_HOLD: if (tmr_done) begin
                    if (use_poll) begin
                        lcd_address   <= LCD_ADDR_BUSY_R;
                        lcd_writedata <= 8'h00;
                        poll_cnt      <= '0;
                        state         <= S_POLL_SETUP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: ;
                S_POLL_SETUP: if (tmr_done) begin
                    lcd_read <= 1'b1;
                    state    <= S_POLL_E;
                end
                S_POLL_E: if (tmr_done) begin
                    lcd_read <= 1'b0;
                    bf_q     <= lcd_readdata[7];
                    state    <= S_POLL_HOLD;
                end
                S_POLL_HOLD: if (tmr_done && bf_q) begin
                    if (poll_hit) busy_timeout <= 1'b1;
                    else          state        <= S_POLL_SETUP;
                end
                default: state <= S_POWERON;
            endcase
            // Byte complete: advance the init ROM or return to idle.
            if (finish) begin
                if (!init_done && step != 3'(INIT_LEN - 1)) begin
                    step  <= step + 3'd1;
                    state <= S_INIT_LOAD;
                end else begin
                    init_done <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: doc/lcd_char_sequencer.md
Name: lcd_char_sequencer

Overview:
- Upstream master for the HD44780 LCD Avalon slave, which is purely combinational: RW=address[0], RS=address[1], E=read|write, data tri-stated when address[0]=1.
- This block owns all bus timing: address setup, E pulse width, address hold, post-command delay, and busy-flag polling.
- Runs the power-on init sequence, then accepts command/data bytes from software or a text FIFO over a valid/ready handshake.

Parameters:
- SETUP_CYC, 3, cycles address is stable before E rises (>=60 ns).
- E_CYC, 23, cycles E is held high (>=450 ns at 50 MHz).
- HOLD_CYC, 2, cycles address and data are held after E falls.
- POWERON_CYC, 750000, initial wait after reset (15 ms).
- INIT_WAIT_CYC, 205000, wait after each of the first three 0x38 writes (4.1 ms).
- CMD_WAIT_CYC, 2000, fixed post-write wait (40 us).
- CLEAR_WAIT_CYC, 82000, fixed wait after clear/home (1.64 ms).
- USE_BUSY, 1, 1 = poll the busy flag after init step 3; 0 = use fixed waits only.
- BUSY_TIMEOUT_CYC, 100000, maximum cycles spent polling for one byte.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  byte offered
- in_ready  out  1  sequencer can accept a byte
- in_rs  in  1  0 = command, 1 = character data
- in_data  in  8  byte to write
- init_done  out  1  init sequence complete (sticky until reset)
- busy_timeout  out  1  sticky: a poll exceeded BUSY_TIMEOUT_CYC
- lcd_address  out  2  to slave address ({RS,RW})
- lcd_read  out  1  to slave read
- lcd_write  out  1  to slave write
- lcd_writedata  out  8  to slave writedata
- lcd_readdata  in  8  from slave readdata (bit 7 = BF)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n), sampled at the clk edge.
- Reset values: all outputs 0 (lcd_address=2'b00). Reset asserted mid-transfer aborts it; read/write drop at the next edge; the FSM restarts at S_POWERON.
- States: S_POWERON -> S_INIT_LOAD -> (S_SETUP -> S_EHIGH -> S_HOLD -> S_WAIT | S_POLL_SETUP -> S_POLL_E -> S_POLL_HOLD) -> S_IDLE.
- Init ROM: 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
  - Steps 0–2 always wait INIT_WAIT_CYC.
  - Steps 3–6 complete like normal writes.
  - After step 6 completes: init_done=1, enter S_IDLE.
- Handshake:
  - in_ready=1 only in S_IDLE.
  - A byte is accepted on an edge where in_valid&&in_ready; {in_rs,in_data} is latched and in_ready=0 from the next cycle.
  - in_valid while not ready is ignored; no data is lost because the producer holds.
- Write transfer timing, counted from the cycle after accept:
  - S_SETUP: lcd_address={rs,0}, lcd_writedata=byte, lcd_write=0, for SETUP_CYC cycles.
  - S_EHIGH: lcd_write=1 for exactly E_CYC cycles.
  - S_HOLD: lcd_write=0, address and data unchanged, for HOLD_CYC cycles.
- Completion when USE_BUSY=1 and init step >=3 (or any user byte):
  - Poll: lcd_address=2'b01, lcd_writedata=0, SETUP_CYC cycles.
  - lcd_read=1 for E_CYC cycles; BF=lcd_readdata[7] is sampled on the last E-high cycle.
  - HOLD_CYC cycles with read=0.
  - BF=1: repoll. BF=0: S_IDLE.
- Poll timeout: a counter runs from the first poll cycle. On reaching BUSY_TIMEOUT_CYC, the poll finishes its current hold, then sets busy_timeout=1 and goes to S_IDLE.
- Completion otherwise: S_WAIT for CLEAR_WAIT_CYC if rs=0 and data∈{0x01,0x02,0x03}, else CMD_WAIT_CYC; then S_IDLE.
- lcd_read and lcd_write are never both 1. Address never changes while read|write=1.
- All counters are sized for the largest parameter. A zero-cycle parameter is treated as 1.

Decomposition:
- Package lcd_seq_pkg:
  - State enum.
  - Address encodings: LCD_ADDR_CMD_W=2'b00, LCD_ADDR_BUSY_R=2'b01, LCD_ADDR_DATA_W=2'b10.
  - Init ROM constants: LCD_FUNCSET=8'h38, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY=8'h06.
  - Init ROM length 7.
- Sub-module lcd_seq_timer: loadable down-counter with a done flag, shared by all phase and wait timing.

Test Plan (SETUP=2, E=4, HOLD=1, POWERON=20, INIT_WAIT=10, CMD_WAIT=5, CLEAR_WAIT=15, BUSY_TIMEOUT=50):
- Reset release, lcd_readdata=0x00 -> 20 idle cycles; 7 write strobes with data 38,38,38,38,0C,01,06, each exactly 4 cycles; polls start after the 4th write; init_done rises; in_ready=1.
- Data byte 0x41 (rs=1), USE_BUSY=0 -> address=2'b10 two cycles before write; write high 4 cycles; 1 hold cycle; 5 wait cycles; in_ready back. Total 12 cycles after accept.
- Command 0x01 (rs=0), USE_BUSY=0 -> 15-cycle wait, versus 5 for 0x80.
- BF held 1 for 3 polls then 0 -> 4 read strobes at address 2'b01, each 4 cycles; then idle; busy_timeout=0.
- BF stuck 1 -> busy_timeout=1 within 50+7 poll cycles; return to S_IDLE.
- reset_n low during S_EHIGH -> lcd_write=0 next edge; all outputs 0; init sequence restarts on release.
